// File: rtl/mac_layer.sv
// Broadcast-sample fully-connected layer: NUM_CH signed MAC channels,
// two-stage multiply/accumulate, optional ReLU and saturating output.
module mac_layer #(
  parameter int NUM_CH = 32,
  parameter int LEN    = 784,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 42,
  parameter int OUT_W  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_relu_en,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [DATA_W-1:0]        i_in_data,
  input  logic [NUM_CH*DATA_W-1:0] i_w_flat,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [NUM_CH*OUT_W-1:0]  o_p_flat,
  output logic                     o_busy
);

  localparam int CW = $clog2(LEN + 1);
  localparam int PW = 2 * DATA_W;
  localparam int SW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [SW-1:0] L_MAX =
    {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] L_MIN =
    {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_FINAL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]            r_cnt;
  logic                     r_relu;
  logic                     r_s1_vld;
  logic signed [DATA_W-1:0] r_im;
  logic [NUM_CH*DATA_W-1:0] r_w;
  logic signed [ACC_W-1:0]  r_acc [NUM_CH];
  logic [NUM_CH*OUT_W-1:0]  r_p;

  logic                     w_accept;
  logic                     w_last;
  logic signed [PW-1:0]     w_prod [NUM_CH];
  logic signed [ACC_W-1:0]  w_ext  [NUM_CH];
  logic signed [ACC_W-1:0]  w_sum  [NUM_CH];
  logic signed [ACC_W-1:0]  w_rl   [NUM_CH];
  logic signed [SW-1:0]     w_wide [NUM_CH];
  logic [OUT_W-1:0]         w_sat  [NUM_CH];

  assign w_accept = i_in_valid && (r_state == S_ACCUM);
  assign w_last   = (r_cnt == CW'(LEN - 1));

  assign o_in_ready  = (r_state == S_ACCUM);
  assign o_out_valid = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_p_flat    = r_p;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_prod[c] = $signed(r_w[c*DATA_W +: DATA_W]) * r_im;
      w_ext[c]  = ACC_W'(w_prod[c]);
      w_sum[c]  = r_acc[c] + w_ext[c];
      w_rl[c]   = (r_relu && r_acc[c][ACC_W-1]) ? '0 : r_acc[c];
      w_wide[c] = SW'(w_rl[c]);
      if (w_wide[c] > L_MAX)
        w_sat[c] = L_MAX[OUT_W-1:0];
      else if (w_wide[c] < L_MIN)
        w_sat[c] = L_MIN[OUT_W-1:0];
      else
        w_sat[c] = w_wide[c][OUT_W-1:0];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_ACCUM;
      S_ACCUM: if (w_accept && w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_FINAL;
      S_FINAL: w_next = S_DONE;
      S_DONE:  if (i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_cnt    <= '0;
      r_relu   <= 1'b0;
      r_s1_vld <= 1'b0;
      r_p      <= '0;
      for (int c = 0; c < NUM_CH; c++)
        r_acc[c] <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_im  <= $signed(i_in_data);
        r_w   <= i_w_flat;
        r_cnt <= r_cnt + CW'(1);
      end
      // A new vector starts from a clean slate
      if (r_state == S_IDLE && i_start) begin
        r_cnt    <= '0;
        r_s1_vld <= 1'b0;
        r_relu   <= i_relu_en;
        for (int c = 0; c < NUM_CH; c++)
          r_acc[c] <= '0;
      end else if (r_s1_vld) begin
        for (int c = 0; c < NUM_CH; c++)
          r_acc[c] <= w_sum[c];
      end
      if (r_state == S_FINAL) begin
        for (int c = 0; c < NUM_CH; c++)
          r_p[c*OUT_W +: OUT_W] <= w_sat[c];
      end
    end
  end

endmodule

// File: tb/tb_mac_layer.sv
// Directed bench for mac_layer: a 16-bit-output instance for function and
// handshake, and an 8-bit-output instance for saturation.
module tb_mac_layer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // instance A: NUM_CH=4 LEN=3 DATA_W=8 ACC_W=24 OUT_W=16
  logic        a_start = 0, a_abort = 0, a_relu = 0, a_vld = 0;
  logic        a_ordy = 0;
  logic [7:0]  a_data = 0;
  logic [31:0] a_w = 0;
  logic        a_irdy, a_ov, a_busy;
  logic [63:0] a_p;

  mac_layer #(
    .NUM_CH(4), .LEN(3), .DATA_W(8), .ACC_W(24), .OUT_W(16)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_abort(a_abort),
    .i_relu_en(a_relu), .i_in_valid(a_vld), .o_in_ready(a_irdy),
    .i_in_data(a_data), .i_w_flat(a_w), .o_out_valid(a_ov),
    .i_out_ready(a_ordy), .o_p_flat(a_p), .o_busy(a_busy)
  );

  // instance B: NUM_CH=4 LEN=4 DATA_W=8 ACC_W=24 OUT_W=8
  logic        b_start = 0, b_relu = 0, b_vld = 0, b_ordy = 0;
  logic [7:0]  b_data = 0;
  logic [31:0] b_w = 0;
  logic        b_irdy, b_ov, b_busy;
  logic [31:0] b_p;

  mac_layer #(
    .NUM_CH(4), .LEN(4), .DATA_W(8), .ACC_W(24), .OUT_W(8)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_abort(1'b0),
    .i_relu_en(b_relu), .i_in_valid(b_vld), .o_in_ready(b_irdy),
    .i_in_data(b_data), .i_w_flat(b_w), .o_out_valid(b_ov),
    .i_out_ready(b_ordy), .o_p_flat(b_p), .o_busy(b_busy)
  );

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] w4(input int c0, input int c1,
                                     input int c2, input int c3);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic logic [63:0] p4(input int c0, input int c1,
                                     input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic start_a(input logic relu);
    a_start = 1; a_relu = relu;
    @(negedge clk);
    a_start = 0;
  endtask

  task automatic feed_a(input int d, input logic [31:0] w);
    a_vld = 1; a_data = 8'(d); a_w = w;
    @(negedge clk);
    a_vld = 0; a_data = 8'h5a; a_w = 32'hdeadbeef;
  endtask

  task automatic vec1_a();
    feed_a(1, w4(1, 2, -5, 0));
    feed_a(2, w4(1, 0, -5, 0));
    feed_a(3, w4(1, -1, -5, 0));
  endtask

  task automatic wait_a(input string tag);
    for (int i = 0; i < 40 && !a_ov; i++) @(negedge clk);
    check(tag, a_ov, 1);
  endtask

  task automatic pop_a(input string tag);
    a_ordy = 1;
    @(negedge clk);
    a_ordy = 0;
    check(tag, a_ov, 0);
  endtask

  task automatic run_b(input logic relu, input int d, input int w);
    b_start = 1; b_relu = relu;
    @(negedge clk);
    b_start = 0;
    for (int k = 0; k < 4; k++) begin
      b_vld = 1; b_data = 8'(d); b_w = {4{8'(w)}};
      @(negedge clk);
    end
    b_vld = 0;
    for (int i = 0; i < 40 && !b_ov; i++) @(negedge clk);
    check("b_ov_to", b_ov, 1);
  endtask

  task automatic pop_b();
    b_ordy = 1;
    @(negedge clk);
    b_ordy = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_irdy", a_irdy, 0);
    check("rst_ov", a_ov, 0);
    check("rst_busy", a_busy, 0);
    check("rst_p", a_p, 0);
    rst = 0;
    @(negedge clk);

    // continuous vector with exact latency
    start_a(0);
    check("t1_busy", a_busy, 1);
    check("t1_irdy", a_irdy, 1);
    vec1_a();
    check("t1_ov_e1", a_ov, 0);
    check("t1_irdy_e1", a_irdy, 0);
    @(negedge clk);
    check("t1_ov_e2", a_ov, 0);
    @(negedge clk);
    check("t1_ov_e3", a_ov, 1);
    check("t1_p", a_p, p4(6, -1, -30, 0));
    pop_a("t1_pop");
    check("t1_idle", a_busy, 0);

    // bubbles between samples 1 and 2
    start_a(0);
    feed_a(1, w4(1, 2, -5, 0));
    a_data = 8'h7f; a_w = 32'h7f7f7f7f;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_cnt", dut_a.r_cnt, 1);
    end
    feed_a(2, w4(1, 0, -5, 0));
    feed_a(3, w4(1, -1, -5, 0));
    wait_a("t2_ov");
    check("t2_p", a_p, p4(6, -1, -30, 0));
    pop_a("t2_pop");

    // ReLU on
    start_a(1);
    vec1_a();
    wait_a("t3_ov");
    check("t3_p", a_p, p4(6, 0, 0, 0));
    pop_a("t3_pop");

    // relu_en toggled mid-vector has no effect
    start_a(0);
    feed_a(1, w4(1, 2, -5, 0));
    a_relu = 1;
    feed_a(2, w4(1, 0, -5, 0));
    feed_a(3, w4(1, -1, -5, 0));
    wait_a("t4_ov");
    check("t4_p", a_p, p4(6, -1, -30, 0));
    pop_a("t4_pop");
    a_relu = 0;

    // abort after two accepts
    start_a(0);
    feed_a(7, w4(9, 9, 9, 9));
    feed_a(7, w4(9, 9, 9, 9));
    a_abort = 1;
    @(negedge clk);
    a_abort = 0;
    check("t5_busy", a_busy, 0);
    check("t5_p", a_p, 0);
    check("t5_irdy", a_irdy, 0);
    start_a(0);
    vec1_a();
    wait_a("t5_ov");
    check("t5_p2", a_p, p4(6, -1, -30, 0));
    pop_a("t5_pop");

    // start and abort together
    a_start = 1; a_abort = 1;
    @(negedge clk);
    a_start = 0; a_abort = 0;
    check("t6_busy", a_busy, 0);
    @(negedge clk);
    check("t6_busy2", a_busy, 0);

    // long hold in DONE, stray in_valid ignored
    start_a(0);
    vec1_a();
    wait_a("t7_ov");
    a_vld = 1; a_data = 8'd100; a_w = w4(50, 50, 50, 50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t7_p_hold", a_p, p4(6, -1, -30, 0));
      check("t7_irdy", a_irdy, 0);
      check("t7_ov_hold", a_ov, 1);
    end
    a_vld = 0;
    pop_a("t7_pop");
    start_a(0);
    feed_a(-1, w4(3, 1, 127, -1));
    feed_a(4, w4(3, -2, 0, -1));
    feed_a(2, w4(3, 0, -128, -1));
    wait_a("t7_ov2");
    check("t7_p2", a_p, p4(15, -9, -383, -5));
    pop_a("t7_pop2");

    // saturation on the 8-bit output instance
    run_b(0, 127, 127);
    check("b_pos_sat", b_p, 32'h7f7f7f7f);
    pop_b();
    run_b(0, 127, -128);
    check("b_neg_sat", b_p, 32'h80808080);
    pop_b();
    run_b(1, 127, -128);
    check("b_relu_neg", b_p, 0);
    pop_b();
    run_b(0, 3, 2);
    check("b_small", b_p, 32'h18181818);
    pop_b();
    check("b_idle", b_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mac_layer.md
# mac_layer

Parametrised fully-connected layer engine: NUM_CH signed multiply-accumulate channels share one broadcast input sample stream and produce one dot product per channel over a LEN-sample input vector. It is the generalised successor to the fixed 32-channel first-stage array, with configurable width, depth and channel count. It adds a valid/ready input stream, an internal sample counter, optional ReLU, output saturation, and an output handshake, so one instance serves every MNIST layer between the picoRV32 bus glue and the argmax stage.

## Interface
- NUM_CH, 32: number of MAC channels (≥1)
- LEN, 784: samples per input vector (≥1)
- DATA_W, 16: signed width of image sample and each weight
- ACC_W, 42: signed accumulator width; must be ≥ 2*DATA_W + clog2(LEN)
- OUT_W, 32: signed width of each result
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new vector; honoured only in IDLE
- abort  in  1  cancel current operation, return to IDLE
- relu_en  in  1  apply ReLU to results; sampled when start is honoured
- in_valid  in  1  in_data/w_flat valid
- in_ready  out  1  block accepts a sample this cycle
- in_data  in  DATA_W  signed input sample, broadcast to all channels
- w_flat  in  NUM_CH*DATA_W  signed weights for this sample; channel c at bits [c*DATA_W +: DATA_W]
- out_valid  out  1  p_flat holds a completed result
- out_ready  in  1  downstream consumes result
- p_flat  out  NUM_CH*OUT_W  results; channel c at bits [c*OUT_W +: OUT_W]
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCUM, DRAIN, FINAL, DONE.
- IDLE: in_ready=0. When start=1 and abort=0: clear all accumulators, count, and pipeline valid; latch relu_en; go to ACCUM.
- ACCUM: in_ready=1. On accept (in_valid & in_ready), register in_data, w_flat and a valid bit into stage-1 registers, and increment count. On the accept with count==LEN-1, go to DRAIN; in_ready is 0 from the next cycle.
- Stage 2 (every state): if stage-1 valid, acc[c] <= acc[c] + sext(w_r[c]*im_r). The product is a full 2*DATA_W signed value sign-extended to ACC_W; the accumulator wraps modulo 2^ACC_W.
- DRAIN: the final stage-2 accumulate completes; go to FINAL.
- FINAL: p[c] <= sat_OUT_W(relu ? max(acc[c],0) : acc[c]); saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Set out_valid; go to DONE.
- DONE: out_valid=1 and p_flat stable. When out_ready=1, clear out_valid and go to IDLE on that edge. p_flat keeps its value until the next FINAL, abort or rst.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored; no sample is consumed.
- abort (any state): on the next edge go to IDLE; clear acc, count, stage-1 valid, out_valid and p_flat to 0. abort beats start in the same cycle.
- rst: identical clearing; rst beats abort and start.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, p_flat=0; state IDLE, acc=0, count=0.
- start sampled at edge S: busy=1 and in_ready=1 from edge S onward. A sample can be accepted at edge S+1 at the earliest.
- Last sample accepted at edge E: acc final at E+1 (DRAIN); p_flat and out_valid=1 at E+2. Minimum start-to-out_valid is LEN+2 cycles.
- Input bubbles (in_valid=0) stall count and accumulation without loss. There is no limit on bubble length.
- out_valid holds indefinitely until out_ready. Handshake completes at the edge where out_valid & out_ready. A start in the cycle after return to IDLE is honoured, giving back-to-back vectors with 1 idle cycle.
- LEN=1: ACCUM→DRAIN on the first accept; out_valid two edges later.

## Test plan
- NUM_CH=4, LEN=3, DATA_W=8, relu_en=0: samples 1,2,3 with weights ch0=(1,1,1), ch1=(2,0,-1), ch2=(-5,-5,-5), ch3=(0,0,0), fed continuously → p={6,-1,-30,0}, out_valid exactly 2 cycles after the third accept.
- Same vector with in_valid de-asserted for 5 cycles between samples 1 and 2 → identical p; count stays at 1 throughout the gap.
- relu_en=1, same weights → p={6,0,0,0}. relu_en toggled mid-vector → no effect.
- OUT_W=8, ACC_W=24, LEN=4, all samples and weights 127 → p=127 per channel (saturated). All weights -128, samples 127 → p=-128.
- abort asserted after 2 of 3 accepts → next cycle busy=0, p_flat=0. A fresh vector afterwards yields correct results with no residue. start+abort in the same cycle → stays IDLE.
- out_ready held 0 for 10 cycles in DONE → p_flat stable and in_ready=0. Then out_ready=1 → out_valid drops next edge. start one cycle later → second vector accepted and computed correctly.
